chime_mix_fader: RTL and testbench



---
 rtl/chime_mix_fader.sv | 91 +++++++++
 tb/tb_chime_mix_fader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/chime_mix_fader.sv
// Two-slot chime mixer with a linearly ramped master gain, producing an
// offset-binary sample plus valid strobe for the delta-sigma DAC.
module chime_mix_fader #(
  parameter int C_FADE_DIV = 16,
  parameter int C_OUT_W    = 10
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               EE_SMPL_i,
  input  logic [15:0]        WAVE0s_i,
  input  logic [15:0]        WAVE1s_i,
  input  logic               MUTE_i,
  input  logic [6:0]         VOLs_i,
  output logic [C_OUT_W-1:0] DATs_o,
  output logic               DAT_VLD_o,
  output logic [6:0]         GAINs_o,
  output logic               FADING_o,
  output logic               MUTED_o
);

  localparam int                 SC_W    = (C_FADE_DIV > 1) ? $clog2(C_FADE_DIV) : 1;
  localparam logic [SC_W-1:0]    SC_LAST = SC_W'(C_FADE_DIV - 1);
  localparam logic [C_OUT_W-1:0] MID     = {1'b1, {(C_OUT_W-1){1'b0}}};

  logic [6:0]         gain;
  logic [6:0]         target;
  logic [SC_W-1:0]    sc;
  logic               v1;
  logic               v2;
  logic signed [16:0] sum;
  logic signed [16:0] prod;
  logic signed [24:0] prod_full;
  logic [C_OUT_W-1:0] dat_next;

  always_comb begin
    target = 7'd0;
    if (!MUTE_i) target = (VOLs_i > 7'd64) ? 7'd64 : VOLs_i;
  end

  // Gain ramp: one step of +-1 every C_FADE_DIV strobes while off target.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      gain     <= 7'd0;
      sc       <= '0;
      FADING_o <= 1'b0;
      MUTED_o  <= 1'b1;
    end else begin
      FADING_o <= (gain != target);
      MUTED_o  <= (gain == 7'd0);
      if (gain == target) begin
        sc <= '0;
      end else if (EE_SMPL_i) begin
        if (sc == SC_LAST) begin
          sc   <= '0;
          gain <= (gain < target) ? gain + 7'd1 : gain - 7'd1;
        end else begin
          sc <= sc + SC_W'(1);
        end
      end
    end
  end

  assign GAINs_o = gain;

  // Gain is 0..64 unsigned; a zero sign bit keeps the product signed.
  always_comb prod_full = sum * $signed({1'b0, gain});

  // Top C_OUT_W bits of the 17-bit product, MSB flipped to offset binary.
  always_comb dat_next = C_OUT_W'(prod >>> (17 - C_OUT_W)) ^ MID;

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      DAT_VLD_o <= 1'b0;
      sum       <= '0;
      prod      <= '0;
      DATs_o    <= MID;
    end else begin
      v1        <= EE_SMPL_i;
      v2        <= v1;
      DAT_VLD_o <= v2;
      if (EE_SMPL_i) sum <= {WAVE0s_i[15], WAVE0s_i} + {WAVE1s_i[15], WAVE1s_i};
      if (v1)        prod <= 17'(prod_full >>> 6);
      if (v2)        DATs_o <= dat_next;
    end
  end

endmodule

// File: tb/tb_chime_mix_fader.sv
// Randomized bench for chime_mix_fader against a strobe-level gain/sample model.
module tb_chime_mix_fader;

  localparam int FADE_DIV = 16;
  localparam int OUT_W    = 10;

  logic             ck    = 1'b0;
  logic             rst   = 1'b1;
  logic             smpl  = 1'b0;
  logic             mute  = 1'b1;
  logic [15:0]      w0    = '0;
  logic [15:0]      w1    = '0;
  logic [6:0]       vol   = '0;
  logic [OUT_W-1:0] dat;
  logic             dat_vld;
  logic [6:0]       gain;
  logic             fading;
  logic             muted;

  chime_mix_fader #(.C_FADE_DIV(FADE_DIV), .C_OUT_W(OUT_W)) dut (
    .CK_i      (ck),
    .RST_i     (rst),
    .EE_SMPL_i (smpl),
    .WAVE0s_i  (w0),
    .WAVE1s_i  (w1),
    .MUTE_i    (mute),
    .VOLs_i    (vol),
    .DATs_o    (dat),
    .DAT_VLD_o (dat_vld),
    .GAINs_o   (gain),
    .FADING_o  (fading),
    .MUTED_o   (muted)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: gain advances once per FADE_DIV off-target strobes;
  // each strobe yields floor((w0+w1)*g/64), requantised to OUT_W offset binary.
  typedef struct {
    int val;
    int cyc;
  } sample_t;

  sample_t pend[$];
  int      cyc        = 0;
  int      mg         = 0;
  int      msc        = 0;
  int      exp_dat    = 1 << (OUT_W - 1);
  int      exp_fading = 0;
  int      exp_muted  = 1;
  bit      checking   = 1'b0;

  function automatic int sample_of(input logic [15:0] a, input logic [15:0] b, input int g);
    int s;
    int p;
    s = int'($signed(a)) + int'($signed(b));
    p = (s * g) >>> 6;
    return (p >>> (17 - OUT_W)) + (1 << (OUT_W - 1));
  endfunction

  always @(posedge ck) begin : model
    int t;
    t = mute ? 0 : ((int'(vol) > 64) ? 64 : int'(vol));
    if (rst) begin
      mg = 0;
      msc = 0;
      exp_fading = 0;
      exp_muted = 1;
      exp_dat = 1 << (OUT_W - 1);
      pend.delete();
    end else begin
      exp_fading = (mg != t) ? 1 : 0;
      exp_muted  = (mg == 0) ? 1 : 0;
      if (mg == t) begin
        msc = 0;
      end else if (smpl) begin
        msc++;
        if (msc == FADE_DIV) begin
          msc = 0;
          mg += (t > mg) ? 1 : -1;
        end
      end
      if (smpl) pend.push_back('{sample_of(w0, w1, mg), cyc});
    end
    cyc++;
  end

  // Output sample is due three clock cycles after the strobe cycle.
  always @(negedge ck) begin
    if (checking) begin
      check("gain", int'(gain), mg);
      check("fading", int'(fading), exp_fading);
      check("muted", int'(muted), exp_muted);
      if (pend.size() > 0 && cyc - pend[0].cyc == 3) begin
        check("vld_due", int'(dat_vld), 1);
        exp_dat = pend[0].val;
        void'(pend.pop_front());
      end else begin
        check("vld_idle", int'(dat_vld), 0);
      end
      check("dat", int'(dat), exp_dat);
    end
  end

  task automatic step_clk();
    @(posedge ck);
    #1;
  endtask

  task automatic strobe(input int gap, input logic [15:0] a, input logic [15:0] b);
    w0 = a;
    w1 = b;
    smpl = 1'b1;
    step_clk();
    smpl = 1'b0;
    repeat (gap - 1) step_clk();
  endtask

  task automatic rnd_strobe(input int gap);
    strobe(gap, 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_gain(input int g);
    int n;
    n = 0;
    while (int'(gain) != g && n < 2000) begin
      rnd_strobe(2);
      n++;
    end
    check("wait_gain", int'(gain), g);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dat"}, int'(dat), 'h200);
    check({tag, "_vld"}, int'(dat_vld), 0);
    check({tag, "_gain"}, int'(gain), 0);
    check({tag, "_muted"}, int'(muted), 1);
    check({tag, "_fading"}, int'(fading), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step_clk();
    check_reset_state("rst");
    rst = 1'b0;
    checking = 1'b1;

    // Fade-in to unity.
    mute = 1'b0;
    vol  = 7'd64;
    repeat (16) rnd_strobe(4);
    check("fadein_g1", int'(gain), 1);
    step_clk();
    check("fadein_unmuted", int'(muted), 0);
    check("fadein_fading", int'(fading), 1);
    repeat (1008) rnd_strobe(4);
    check("fadein_g64", int'(gain), 64);
    step_clk();
    check("fadein_done", int'(fading), 0);

    strobe(4, 16'h4000, 16'h2000);
    check("unity", int'(dat), 'h2C0);
    strobe(4, 16'h8000, 16'h8000);
    check("neg_fs", int'(dat), 'h000);

    // Targets above 64 clamp.
    vol = 7'd100;
    repeat (40) rnd_strobe(2);
    check("clamp_gain", int'(gain), 64);
    check("clamp_fading", int'(fading), 0);

    vol = 7'd32;
    repeat (512) rnd_strobe(2);
    check("half_gain", int'(gain), 32);
    strobe(4, 16'h4000, 16'h2000);
    check("half_dat", int'(dat), 'h260);

    // Reversal: up to 40, mute down to 20, release and climb again.
    vol = 7'd64;
    wait_gain(40);
    mute = 1'b1;
    wait_gain(20);
    mute = 1'b0;
    repeat (16) rnd_strobe(2);
    check("reverse_g21", int'(gain), 21);
    mute = 1'b1;
    wait_gain(0);
    rnd_strobe(4);
    check("silent_dat", int'(dat), 'h200);
    check("silent_muted", int'(muted), 1);

    // Random strobe spacing (including back-to-back) and target changes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        mute = ($urandom_range(0, 3) == 0);
        vol  = 7'($urandom_range(0, 127));
      end
      rnd_strobe(int'($urandom_range(1, 4)));
    end

    // Reset with a sample in flight must drop it.
    mute = 1'b0;
    vol  = 7'd64;
    rnd_strobe(1);
    rst = 1'b1;
    repeat (2) step_clk();
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (6) step_clk();
    check("midrst_nosample", pend.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
